// File: rtl/master_reset_filter.sv
// Master reset request filter: synchronize, qualify, stretch and hold off the master FPGA reset line.
// Optional event counters are compiled in with `define MASTER_RST_EVENT_CNT_EN.
module master_reset_filter #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned MIN_WIDTH   = 16,
  parameter int unsigned HOLDOFF_LEN = 32
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       rst_req_raw,
  input  logic       cnt_clr,
  output logic       rst_from_master,
  output logic       busy,
  output logic [7:0] rst_count,
  output logic [7:0] glitch_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   FILTER_C  = (CNT_W+1)'(FILTER_LEN);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(HOLDOFF_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  (* ASYNC_REG = "TRUE" *) logic req_meta;
  (* ASYNC_REG = "TRUE" *) logic req_s;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept_c;
  logic             glitch_c;

  // Two-flop synchronizer for the asynchronous request pin
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= rst_req_raw;
      req_s    <= req_meta;
    end
  end

  // State and shared cycle counter
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and event strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    glitch_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_s) begin
          cnt_nxt = CNT_ONE;
          if (FILTER_LEN == 1) begin
            state_nxt = ASSERT;
            accept_c  = 1'b1;
          end else begin
            state_nxt = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (!req_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          glitch_c  = 1'b1;
        end else if ((CNT_W+1)'(cnt) + (CNT_W+1)'(1) == FILTER_C) begin
          state_nxt = ASSERT;
          cnt_nxt   = CNT_ONE;
          accept_c  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ASSERT: begin
        if (cnt >= MIN_C && !req_s) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (cnt >= HOLDOFF_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs registered from the next state so they change on the transition edge
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      rst_from_master <= 1'b0;
      busy            <= 1'b0;
    end else begin
      rst_from_master <= (state_nxt == ASSERT);
      busy            <= (state_nxt != IDLE);
    end
  end

`ifdef MASTER_RST_EVENT_CNT_EN
  // Saturating event counters; clear wins over a coincident increment
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      rst_count    <= '0;
      glitch_count <= '0;
    end else if (cnt_clr) begin
      rst_count    <= '0;
      glitch_count <= '0;
    end else begin
      if (accept_c && rst_count != CNT_MAX) begin
        rst_count <= rst_count + CNT_ONE;
      end
      if (glitch_c && glitch_count != CNT_MAX) begin
        glitch_count <= glitch_count + CNT_ONE;
      end
    end
  end
`else
  logic unused_evt;
  assign unused_evt   = ^{cnt_clr, accept_c, glitch_c};
  assign rst_count    = '0;
  assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_master_reset_filter.sv
// Scoreboard bench for master_reset_filter: expected pulses queued at drive time, checked at rst_from_master fall.
module tb_master_reset_filter;

  localparam int unsigned FILTER_LEN  = 8;
  localparam int unsigned MIN_WIDTH   = 16;
  localparam int unsigned HOLDOFF_LEN = 32;
`ifdef MASTER_RST_EVENT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    string tag;
    int    raw_edge;
    int    lat;
    int    width;
  } exp_t;

  logic       clk50;
  logic       rst;
  logic       rst_req_raw;
  logic       cnt_clr;
  logic       rst_from_master;
  logic       busy;
  logic [7:0] rst_count;
  logic [7:0] glitch_count;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   edge_n    = 0;
  int   rise_edge = 0;
  int   rise_cnt  = 0;
  int   exp_rst   = 0;
  int   exp_glt   = 0;
  bit   mon_en    = 1'b1;
  logic rfm_q     = 1'b0;

  master_reset_filter #(
    .FILTER_LEN (FILTER_LEN),
    .MIN_WIDTH  (MIN_WIDTH),
    .HOLDOFF_LEN(HOLDOFF_LEN)
  ) dut (
    .clk50          (clk50),
    .rst            (rst),
    .rst_req_raw    (rst_req_raw),
    .cnt_clr        (cnt_clr),
    .rst_from_master(rst_from_master),
    .busy           (busy),
    .rst_count      (rst_count),
    .glitch_count   (glitch_count)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  always @(posedge clk50) edge_n++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int cnt_exp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: time each rst_from_master pulse and compare against the queued expectation
  always @(negedge clk50) begin
    if (rst_from_master && !rfm_q) begin
      rise_edge = edge_n;
      rise_cnt++;
    end
    if (!rst_from_master && rfm_q && mon_en) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, "_latency"}, rise_edge - mon_e.raw_edge + 1, mon_e.lat);
        check({mon_e.tag, "_width"}, edge_n - rise_edge, mon_e.width);
      end
    end
    rfm_q = rst_from_master;
  end

  // kind: 0 = expected glitch, 1 = expected accept, 2 = expected to be ignored
  task automatic drive_pulse(input string tag, input int len, input int kind);
    exp_t e;
    @(negedge clk50);
    if (kind == 1) begin
      e.tag      = tag;
      e.raw_edge = edge_n + 1;
      e.lat      = FILTER_LEN + 2;
      e.width    = max2(MIN_WIDTH, len + 1 - FILTER_LEN);
      sb_q.push_back(e);
      exp_rst = sat(exp_rst + 1);
    end else if (kind == 0) begin
      exp_glt = sat(exp_glt + 1);
    end
    rst_req_raw = 1'b1;
    repeat (len) @(negedge clk50);
    rst_req_raw = 1'b0;
  endtask

  task automatic wait_rfm(input string tag, input logic val, input int budget);
    int n = 0;
    while (rst_from_master !== val && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check(tag, int'(rst_from_master), int'(val));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rst_count"}, int'(rst_count), cnt_exp(exp_rst));
    check({tag, "_glitch_count"}, int'(glitch_count), cnt_exp(exp_glt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int rises;
    int n;
    bit hi_seen;
    rst = 1'b1;
    rst_req_raw = 1'b0;
    cnt_clr = 1'b0;
    repeat (3) @(negedge clk50);
    check("reset_rfm", int'(rst_from_master), 0);
    check("reset_busy", int'(busy), 0);
    check_counts("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk50);

    // Long request, then a second request that lands entirely inside holdoff
    drive_pulse("p40", 40, 1);
    check("p40_rfm_mid", int'(rst_from_master), 1);
    check("p40_busy_mid", int'(busy), 1);
    wait_rfm("p40_fall", 1'b0, 20);
    rises = rise_cnt;
    repeat (8) @(negedge clk50);
    drive_pulse("p20_holdoff", 20, 2);
    repeat (40) @(negedge clk50);
    check("holdoff_ignored_rises", rise_cnt - rises, 0);
    check_counts("p40");

    // Short glitch
    rises = rise_cnt;
    drive_pulse("p5", 5, 0);
    repeat (8) @(negedge clk50);
    check("p5_busy_idle", int'(busy), 0);
    check("p5_rises", rise_cnt - rises, 0);
    check_counts("p5");

    // Minimum-width stretch followed by exact holdoff length
    drive_pulse("p9", 9, 1);
    wait_rfm("p9_rise", 1'b1, 20);
    wait_rfm("p9_fall", 1'b0, 40);
    hi_seen = 1'b0;
    repeat (31) begin
      @(negedge clk50);
      if (rst_from_master) hi_seen = 1'b1;
    end
    check("holdoff_rfm_low", int'(hi_seen), 0);
    check("holdoff_busy_last", int'(busy), 1);
    @(negedge clk50);
    check("holdoff_busy_end", int'(busy), 0);
    check_counts("p9");

    // Qualification boundary: one sample short, then exactly enough
    rises = rise_cnt;
    drive_pulse("p7", 7, 0);
    repeat (10) @(negedge clk50);
    check("p7_rises", rise_cnt - rises, 0);
    drive_pulse("p8", 8, 1);
    wait_rfm("p8_rise", 1'b1, 20);
    wait_rfm("p8_fall", 1'b0, 40);
    repeat (40) @(negedge clk50);
    check_counts("p8");

    // Reset in the middle of ASSERT
    mon_en = 1'b0;
    @(negedge clk50);
    rst_req_raw = 1'b1;
    wait_rfm("rstmid_rise", 1'b1, 20);
    repeat (5) @(negedge clk50);
    rst = 1'b1;
    #1;
    check("rstmid_rfm", int'(rst_from_master), 0);
    check("rstmid_busy", int'(busy), 0);
    exp_rst = 0;
    exp_glt = 0;
    check_counts("rstmid");
    @(negedge clk50);
    rst = 1'b0;
    n = 0;
    while (!rst_from_master && n < 30) begin
      @(negedge clk50);
      n++;
    end
    check("rstmid_requalify_latency", n, FILTER_LEN + 2);
    exp_rst = 1;
    rst_req_raw = 1'b0;
    wait_rfm("rstmid_fall", 1'b0, 40);
    repeat (40) @(negedge clk50);
    check_counts("rstmid_after");
    mon_en = 1'b1;

    // Saturate glitch_count, then clear
    repeat (256) begin
      drive_pulse("sat", 3, 0);
      repeat (6) @(negedge clk50);
    end
    check_counts("sat");
    cnt_clr = 1'b1;
    @(negedge clk50);
    cnt_clr = 1'b0;
    exp_rst = 0;
    exp_glt = 0;
    check_counts("clr");

    // Clear coincident with a glitch increment
    @(negedge clk50);
    rst_req_raw = 1'b1;
    repeat (3) @(negedge clk50);
    rst_req_raw = 1'b0;
    repeat (2) @(negedge clk50);
    cnt_clr = 1'b1;
    @(negedge clk50);
    cnt_clr = 1'b0;
    check("clr_coincident_glitch", int'(glitch_count), 0);
    repeat (4) @(negedge clk50);
    drive_pulse("post_clr", 3, 0);
    repeat (6) @(negedge clk50);
    check_counts("post_clr");

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
